// File: rtl/mips_bus_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_bus_arb_pkg
// Purpose  : Shared types and constants for the two-master memory-bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mips_bus_arb_pkg;

  // Arbiter ownership state: idle, or whole-transfer ownership by one master.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  // Master identifiers: 0 = instruction fetch, 1 = data.
  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;

  // Ownership state that corresponds to a granted master id.
  function automatic arb_state_t own_state(input logic id);
    return (id == ARB_M1) ? ARB_OWN1 : ARB_OWN0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_bus_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : mips_bus_arb_pick
// Purpose  : Combinational grant picker for the two-master bus arbiter.
//            One master may be excluded from a decision (the master whose
//            transfer is completing this cycle).
//            MIPS_BUS_ARB_ROUND_ROBIN_EN defined   : round-robin on contention,
//                                                    the master != last_grant wins.
//            MIPS_BUS_ARB_ROUND_ROBIN_EN undefined : fixed priority, master 1
//                                                    (data) wins on contention.
// Revision : 1.0 - initial release
// ============================================================================
module mips_bus_arb_pick
  import mips_bus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       excl_valid,
  input  logic       excl_id,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  logic [1:0] w_req_eff;

  // Remove the excluded master from the candidate set.
  always_comb begin
    w_req_eff = req;
    if (excl_valid) begin
      w_req_eff[excl_id] = 1'b0;
    end
  end

`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
  // Round-robin: on contention the master that was not granted last wins.
  always_comb begin
    grant_valid = |w_req_eff;
    grant_id    = ARB_M0;
    if (w_req_eff == 2'b11) begin
      grant_id = ~last_grant;
    end else if (w_req_eff[1]) begin
      grant_id = ARB_M1;
    end
  end
`else
  // Fixed priority: the data master wins on contention; history is ignored.
  logic w_unused_last_grant;
  assign w_unused_last_grant = last_grant;

  always_comb begin
    grant_valid = |w_req_eff;
    grant_id    = ARB_M0;
    if (w_req_eff[1]) begin
      grant_id = ARB_M1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/mips_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mips_bus_arbiter
// Purpose  : Two-master, one-slave arbiter for the CPU Avalon-style memory
//            bus. Master 0 = instruction fetch, master 1 = data. A granted
//            master owns the slave until its transfer completes
//            (s_waitrequest = 0); completion re-arbitrates on the same edge
//            so alternating masters see no idle bubble.
//            Arbitration mode selected by MIPS_BUS_ARB_ROUND_ROBIN_EN
//            (resolved inside mips_bus_arb_pick).
// Revision : 1.0 - initial release
// ============================================================================
module mips_bus_arbiter
  import mips_bus_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  // master 0 (instruction fetch)
  input  logic [ADDR_WIDTH-1:0]   m0_address,
  input  logic                    m0_read,
  input  logic                    m0_write,
  input  logic [DATA_WIDTH-1:0]   m0_writedata,
  input  logic [DATA_WIDTH/8-1:0] m0_byteenable,
  output logic [DATA_WIDTH-1:0]   m0_readdata,
  output logic                    m0_waitrequest,
  // master 1 (data)
  input  logic [ADDR_WIDTH-1:0]   m1_address,
  input  logic                    m1_read,
  input  logic                    m1_write,
  input  logic [DATA_WIDTH-1:0]   m1_writedata,
  input  logic [DATA_WIDTH/8-1:0] m1_byteenable,
  output logic [DATA_WIDTH-1:0]   m1_readdata,
  output logic                    m1_waitrequest,
  // slave
  output logic [ADDR_WIDTH-1:0]   s_address,
  output logic                    s_read,
  output logic                    s_write,
  output logic [DATA_WIDTH-1:0]   s_writedata,
  output logic [DATA_WIDTH/8-1:0] s_byteenable,
  input  logic [DATA_WIDTH-1:0]   s_readdata,
  input  logic                    s_waitrequest
);

  arb_state_t r_state;
  logic       r_last_grant;

  logic [1:0] w_req;
  logic       w_owned;
  logic       w_owner;
  logic       w_owner_req;
  logic       w_complete;
  logic       w_grant_valid;
  logic       w_grant_id;

  assign w_req       = {m1_read | m1_write, m0_read | m0_write};
  assign w_owned     = (r_state == ARB_OWN0) || (r_state == ARB_OWN1);
  assign w_owner     = (r_state == ARB_OWN1) ? ARB_M1 : ARB_M0;
  assign w_owner_req = w_req[w_owner];
  assign w_complete  = w_owned && w_owner_req && !s_waitrequest;

  // The completing master is excluded so the other master gets the slave next.
  mips_bus_arb_pick u_pick (
    .req         (w_req),
    .excl_valid  (w_complete),
    .excl_id     (w_owner),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  // Ownership FSM: grant from idle, hold until completion, hand off or go idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= ARB_M1;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_valid) begin
            r_state <= own_state(w_grant_id);
          end
        end
        ARB_OWN0, ARB_OWN1: begin
          if (!w_owner_req) begin
            // owner dropped its strobe without completing: release the bus
            r_state <= ARB_IDLE;
          end else if (!s_waitrequest) begin
            r_last_grant <= w_owner;
            r_state      <= w_grant_valid ? own_state(w_grant_id) : ARB_IDLE;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Slave request mux and per-master stall, decoded from the ownership state.
  always_comb begin
    s_address      = '0;
    s_read         = 1'b0;
    s_write        = 1'b0;
    s_writedata    = '0;
    s_byteenable   = '0;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    case (r_state)
      ARB_OWN0: begin
        s_address      = m0_address;
        s_read         = m0_read;
        s_write        = m0_write;
        s_writedata    = m0_writedata;
        s_byteenable   = m0_byteenable;
        m0_waitrequest = s_waitrequest;
      end
      ARB_OWN1: begin
        s_address      = m1_address;
        s_read         = m1_read;
        s_write        = m1_write;
        s_writedata    = m1_writedata;
        s_byteenable   = m1_byteenable;
        m1_waitrequest = s_waitrequest;
      end
      default: begin
      end
    endcase
  end

  // Read data is broadcast; each master qualifies it with its own waitrequest.
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

endmodule
`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mips_bus_arbiter
// Purpose  : Self-checking bench for mips_bus_arbiter: directed scenarios plus
//            a randomized run against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef logic [AW+DW+BW+3:0] ovec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] m0_address, m1_address, s_address;
  logic          m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [BW-1:0] m0_byteenable, m1_byteenable, s_byteenable;
  logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
  logic          m0_waitrequest, m1_waitrequest, s_waitrequest;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state
  int m_owner;      // -1 = nobody owns the slave
  int m_last;
  int seq [2];
  int gq  [$];      // ids of granted transfers, in grant order

  always #5 clk = ~clk;

  mips_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_readdata(s_readdata), .s_waitrequest(s_waitrequest)
  );

  ovec_t dut_out;
  assign dut_out = {s_address, s_read, s_write, s_writedata, s_byteenable,
                    m0_waitrequest, m1_waitrequest};

  // What the bus should show when 'owner' holds the slave (-1 = nobody).
  function automatic ovec_t exp_out(input int owner);
    if (owner == 0)
      return {m0_address, m0_read, m0_write, m0_writedata, m0_byteenable, s_waitrequest, 1'b1};
    else if (owner == 1)
      return {m1_address, m1_read, m1_write, m1_writedata, m1_byteenable, 1'b1, s_waitrequest};
    else
      return {{AW{1'b0}}, 2'b00, {DW{1'b0}}, {BW{1'b0}}, 2'b11};
  endfunction

  function automatic int ref_pick(input bit r0, input bit r1, input int last);
    if (r0 && r1) return RR ? (1 - last) : 1;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic int txn_id(input int n);
    return n * 1000000 + seq[n];
  endfunction

  // Decide who owns the slave after the coming edge, from the current inputs.
  task automatic model_advance();
    bit r0, r1, own_req, other_req;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    if (m_owner < 0) begin
      m_owner = ref_pick(r0, r1, m_last);
      if (m_owner >= 0) gq.push_back(txn_id(m_owner));
    end else begin
      own_req   = (m_owner == 0) ? r0 : r1;
      other_req = (m_owner == 0) ? r1 : r0;
      if (!own_req) begin
        m_owner = -1;
      end else if (!s_waitrequest) begin
        m_last  = m_owner;
        m_owner = other_req ? (1 - m_owner) : -1;
        if (m_owner >= 0) gq.push_back(txn_id(m_owner));
      end
    end
  endtask

  task automatic clear_inputs();
    m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
    m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
    s_readdata = '0; s_waitrequest = 0;
  endtask

  // Pulse reset; returns 1ns after a posedge with reset released.
  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    m_owner = -1;
    m_last  = 1;
    gq.delete();
  endtask

  task automatic test_reset();
    ovec_t idle_vec;
    idle_vec = {{AW{1'b0}}, 2'b00, {DW{1'b0}}, {BW{1'b0}}, 2'b11};
    reset = 1'b0;
    clear_inputs();
    m0_read = 1; m0_address = 32'h0000_0100;
    m1_write = 1; m1_address = 32'h0000_0200; m1_writedata = 32'h1234_5678; m1_byteenable = 4'hF;
    for (int i = 0; i < 3; i++) begin
      s_readdata = $urandom;
      @(posedge clk); #4;
      tests_run++;
      if (dut_out !== idle_vec) begin
        tests_failed++;
        $display("FAIL reset_outputs: got %h expected %h", dut_out, idle_vec);
      end
      tests_run++;
      if ({m0_readdata, m1_readdata} !== {s_readdata, s_readdata}) begin
        tests_failed++;
        $display("FAIL reset_readdata: got %h/%h expected %h", m0_readdata, m1_readdata, s_readdata);
      end
    end
  endtask

  task automatic test_single_read();
    do_reset();
    m0_address = 32'h0000_0010; m0_read = 1; s_waitrequest = 0; s_readdata = 32'hCAFE_0010;
    #3;
    tests_run++;
    if ({s_read, m0_waitrequest} !== 2'b01) begin
      tests_failed++;
      $display("FAIL single_arb_cycle: got s_read=%b m0_wr=%b expected 0/1", s_read, m0_waitrequest);
    end
    @(posedge clk); #4;
    tests_run++;
    if ({s_read, s_address, m0_waitrequest, m0_readdata} !== {1'b1, 32'h0000_0010, 1'b0, 32'hCAFE_0010}) begin
      tests_failed++;
      $display("FAIL single_xfer_cycle: got rd=%b addr=%h wr=%b rdata=%h expected 1/00000010/0/cafe0010",
               s_read, s_address, m0_waitrequest, m0_readdata);
    end
    @(posedge clk); #1 m0_read = 0; #3;
    tests_run++;
    if ({s_read, m0_waitrequest, m1_waitrequest} !== 3'b011) begin
      tests_failed++;
      $display("FAIL single_back_idle: got %b expected 011", {s_read, m0_waitrequest, m1_waitrequest});
    end
  endtask

  task automatic test_contention();
    int first, g;
    do_reset();
    m0_address = 32'h0000_1000; m1_address = 32'h0000_2000;
    m0_read = 1; m1_read = 1; s_waitrequest = 0;
    first = RR ? 0 : 1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #4;
      g = first ^ (k & 1);
      tests_run++;
      if ({s_read, m0_waitrequest, m1_waitrequest} !== {1'b1, g != 0, g != 1}) begin
        tests_failed++;
        $display("FAIL contention_grant%0d: got rd/wr0/wr1=%b expected master %0d", k,
                 {s_read, m0_waitrequest, m1_waitrequest}, g);
      end
    end
    m0_read = 0; m1_read = 0;
  endtask

  task automatic test_stall();
    int comps;
    ovec_t e;
    comps = 0;
    do_reset();
    m1_address = 32'h2000_0040; m1_write = 1; m1_writedata = 32'hDEAD_BEEF;
    m1_byteenable = 4'b0011; s_waitrequest = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 s_waitrequest = (i == 5) ? 1'b0 : 1'b1; #3;
      e = {32'h2000_0040, 1'b0, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1'b1, s_waitrequest};
      tests_run++;
      if (dut_out !== e) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: got %h expected %h", i, dut_out, e);
      end
      if (m1_write && !m1_waitrequest) comps++;
    end
    @(posedge clk); #1 m1_write = 0; #3;
    tests_run++;
    if ({s_write, comps} !== {1'b0, 32'd1}) begin
      tests_failed++;
      $display("FAIL stall_complete_once: got s_write=%b completions=%0d expected 0/1", s_write, comps);
    end
  endtask

  task automatic test_rearb();
    int exp_own [5] = '{-1, 0, -1, 0, -1};
    ovec_t e;
    do_reset();
    m0_address = 32'h0000_0030; m0_read = 1; s_waitrequest = 0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(posedge clk);
      #3;
      e = exp_out(exp_own[c]);
      tests_run++;
      if (dut_out !== e) begin
        tests_failed++;
        $display("FAIL rearb_cycle%0d: got %h expected %h", c, dut_out, e);
      end
      #1;
    end
    m0_read = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m1_address = 32'h0000_0500; m1_write = 1; m1_writedata = 32'hA5A5_A5A5;
    m1_byteenable = 4'hF; s_waitrequest = 1;
    @(posedge clk); #4;
    tests_run++;
    if ({s_write, m1_waitrequest} !== 2'b11) begin
      tests_failed++;
      $display("FAIL resetmid_owned: got %b expected 11", {s_write, m1_waitrequest});
    end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if ({s_write, m1_waitrequest} !== 2'b01) begin
      tests_failed++;
      $display("FAIL resetmid_async: got s_write/m1_wr=%b expected 01", {s_write, m1_waitrequest});
    end
    m1_write = 0;
    @(posedge clk); #1 reset = 1'b1;
    m0_read = 1; m1_read = 1; s_waitrequest = 0;
    @(posedge clk); #4;
    tests_run++;
    if ({m0_waitrequest, m1_waitrequest} !== (RR ? 2'b01 : 2'b10)) begin
      tests_failed++;
      $display("FAIL resetmid_first_grant: got wr0/wr1=%b expected %b",
               {m0_waitrequest, m1_waitrequest}, RR ? 2'b01 : 2'b10);
    end
    m0_read = 0; m1_read = 0;
  endtask

  task automatic test_random();
    bit pend [2], done [2], is_wr [2];
    int foreign [2];
    int comps;
    bit req_n, wr_n;
    ovec_t e;
    comps = 0;
    do_reset();
    for (int n = 0; n < 2; n++) begin
      pend[n] = 0; done[n] = 0; is_wr[n] = 0; foreign[n] = 0; seq[n] = 0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (done[n]) begin pend[n] = 0; done[n] = 0; end
        if (!pend[n] && ($urandom_range(0, 2) == 0)) begin
          pend[n]  = 1;
          seq[n]   = seq[n] + 1;
          is_wr[n] = 1'($urandom_range(0, 1));
          if (n == 0) begin
            m0_address = {8'h00, 24'(seq[0])}; m0_writedata = $urandom; m0_byteenable = 4'($urandom);
          end else begin
            m1_address = {8'h80, 24'(seq[1])}; m1_writedata = $urandom; m1_byteenable = 4'($urandom);
          end
        end
      end
      m0_read  = pend[0] && !is_wr[0]; m0_write = pend[0] && is_wr[0];
      m1_read  = pend[1] && !is_wr[1]; m1_write = pend[1] && is_wr[1];
      s_waitrequest = 1'($urandom_range(0, 1));
      s_readdata    = $urandom;
      #3;
      e = exp_out(m_owner);
      tests_run++;
      if (dut_out !== e) begin
        tests_failed++;
        $display("FAIL rand_bus cyc%0d: got %h expected %h", cyc, dut_out, e);
      end
      tests_run++;
      if ({m0_readdata, m1_readdata} !== {s_readdata, s_readdata}) begin
        tests_failed++;
        $display("FAIL rand_readdata cyc%0d: got %h/%h expected %h", cyc, m0_readdata, m1_readdata, s_readdata);
      end
      for (int n = 0; n < 2; n++) begin
        req_n = (n == 0) ? (m0_read | m0_write) : (m1_read | m1_write);
        wr_n  = (n == 0) ? m0_waitrequest : m1_waitrequest;
        if (req_n && !wr_n) begin
          comps++;
          tests_run++;
          if (gq.size() == 0 || gq[0] != txn_id(n)) begin
            tests_failed++;
            $display("FAIL rand_order cyc%0d: got completion of %0d expected %0d", cyc, txn_id(n),
                     (gq.size() == 0) ? -1 : gq[0]);
          end
          if (gq.size() != 0) void'(gq.pop_front());
          tests_run++;
          if (foreign[n] > 1) begin
            tests_failed++;
            $display("FAIL rand_starve cyc%0d: got %0d foreign transfers for master %0d expected <=1",
                     cyc, foreign[n], n);
          end
          foreign[n] = 0;
          if (pend[1-n]) foreign[1-n]++;
          done[n] = 1;
        end
      end
      model_advance();
    end
    tests_run++;
    if (comps < 1000 || gq.size() > 1) begin
      tests_failed++;
      $display("FAIL rand_progress: got %0d completions, %0d outstanding grants expected >=1000 and <=1",
               comps, gq.size());
    end
    clear_inputs();
  endtask

  initial begin
    m_owner = -1; m_last = 1;
    seq[0] = 0; seq[1] = 0;
    test_reset();
    test_single_read();
    test_contention();
    test_stall();
    test_rearb();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
